// File: rtl/counter_pkg.sv
// Shared types and defaults for the parametrised up/down counter family.
package counter_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    CNT_WRAP = 2'b00,
    CNT_SAT  = 2'b01,
    CNT_MOD  = 2'b10
  } cnt_mode_e;

  // The reserved encoding 2'b11 behaves exactly like wrap mode.
  function automatic cnt_mode_e decode_mode(input logic [1:0] raw);
    return (raw == 2'b11) ? CNT_WRAP : cnt_mode_e'(raw);
  endfunction

endpackage

// File: rtl/counter_step_unit.sv
// Combinational next-value calculator: one enabled step in the selected
// boundary mode, with terminal-count and illegal-step indications.
module counter_step_unit
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  cnt_mode_e         mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  next_count,
  output logic              tc_next,
  output logic              err_next
);

  // All arithmetic is one bit wider so carries, borrows and limit+1 survive.
  logic [WIDTH:0] ext_count;
  logic [WIDTH:0] ext_step;
  logic [WIDTH:0] ext_limit;
  logic [WIDTH:0] range;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] mod_up;
  logic [WIDTH:0] mod_dn;
  logic           borrow;

  assign ext_count = {1'b0, count};
  assign ext_step  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign ext_limit = {1'b0, limit};
  assign range     = ext_limit + 1'b1;
  assign sum       = ext_count + ext_step;
  assign diff      = ext_count - ext_step;
  assign borrow    = (ext_count < ext_step);
  assign mod_up    = sum - range;
  assign mod_dn    = ext_count + range - ext_step;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_count = count;
    tc_next    = 1'b0;
    err_next   = 1'b0;

    if (step != '0) begin
      unique case (mode)
        CNT_SAT: begin
          if (dir) begin
            if (sum[WIDTH]) begin
              next_count = '1;
              tc_next    = 1'b1;
            end else begin
              next_count = sum[WIDTH-1:0];
            end
          end else begin
            if (borrow) begin
              next_count = '0;
              tc_next    = 1'b1;
            end else begin
              next_count = diff[WIDTH-1:0];
            end
          end
        end

        CNT_MOD: begin
          if (ext_step > range) begin
            err_next = 1'b1;
          end else if (ext_count > ext_limit) begin
            // Limit was lowered below the current count: snap to the rail.
            next_count = dir ? '0 : limit;
            tc_next    = 1'b1;
          end else if (dir) begin
            if (sum > ext_limit) begin
              next_count = mod_up[WIDTH-1:0];
              tc_next    = 1'b1;
            end else begin
              next_count = sum[WIDTH-1:0];
            end
          end else begin
            if (borrow) begin
              next_count = mod_dn[WIDTH-1:0];
              tc_next    = 1'b1;
            end else begin
              next_count = diff[WIDTH-1:0];
            end
          end
        end

        default: begin
          if (dir) begin
            next_count = sum[WIDTH-1:0];
            tc_next    = sum[WIDTH];
          end else begin
            next_count = diff[WIDTH-1:0];
            tc_next    = borrow;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: registers, load/enable priority, clamped
// loading in modulo mode and sticky overflow/error flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf_sticky,
  output logic              err_sticky
);

  cnt_mode_e        cur_mode;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] next_count;
  logic             tc_next;
  logic             err_next;
  logic             step_act;
  logic             tc_set;
  logic             err_set;

  assign cur_mode   = decode_mode(mode);
  assign top_val    = (cur_mode == CNT_MOD) ? limit : '1;
  assign load_value = ((cur_mode == CNT_MOD) && (load_val > limit)) ? limit : load_val;

  counter_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .count      (count),
    .step       (step),
    .dir        (dir),
    .mode       (cur_mode),
    .limit      (limit),
    .next_count (next_count),
    .tc_next    (tc_next),
    .err_next   (err_next)
  );

  // Load pre-empts counting, so step results only matter when load is low.
  assign step_act = en & ~load;
  assign tc_set   = step_act & tc_next;
  assign err_set  = step_act & err_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (load) begin
        count <= load_value;
      end else if (en) begin
        count <= next_count;
      end
      tc <= tc_set;

      // A new set event beats a simultaneous clear.
      if (tc_set) begin
        ovf_sticky <= 1'b1;
      end else if (clr_flags) begin
        ovf_sticky <= 1'b0;
      end

      if (err_set) begin
        err_sticky <= 1'b1;
      end else if (clr_flags) begin
        err_sticky <= 1'b0;
      end
    end
  end

  assign at_max = (count == top_val);
  assign at_min = (count == '0);

endmodule
